darkram_ctrl: RTL and testbench



---
 rtl/darkram_pkg.sv | 30 +++
 rtl/darkram_array.sv | 32 +++
 rtl/darkram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_darkram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkram_pkg.sv
// darkram_pkg: shared types and constants for the darkriscv data RAM slave.
// Build option DARKRAM_PARITY_EN adds one even-parity bit per byte lane.
package darkram_pkg;

  localparam int WORD_W     = 32;
  localparam int LANES      = 4;
  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;

`ifdef DARKRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // One stored lane = data byte plus its optional parity bit (parity on top).
  localparam int LANE_W = BYTE_W + PAR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/darkram_array.sv
// darkram_array: synchronous single-port RAM with per-lane write enables.
// Write and read both happen on the same rising edge (read-before-write).
module darkram_array
  import darkram_pkg::*;
#(
  parameter int    DEPTH     = 512,
  parameter int    IDX_W     = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic                          clk,
  input  logic [LANES-1:0]              wr_mask,
  input  logic [IDX_W-1:0]              idx,
  input  logic [LANES-1:0][LANE_W-1:0]  wdata,
  output logic [LANES-1:0][LANE_W-1:0]  rdata
);

  (* ram_style = "block" *) logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];
  logic [LANES-1:0][LANE_W-1:0] rdata_q;

  // Lane-masked write and registered read of the addressed word.
  // NOTE: the storage array has no reset, so it maps onto block RAM; only the control flops are reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_mask[i]) mem[idx][i] <= wdata[i];
    end
    rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/darkram_ctrl.sv
// darkram_ctrl: darkriscv device-bus slave wrapping darkram_array with a
// request/acknowledge handshake, programmable wait states, byte-enable
// writes and out-of-range error reporting.
// Build option DARKRAM_PARITY_EN adds per-lane parity checking and the PERR port.
module darkram_ctrl
  import darkram_pkg::*;
#(
  parameter int          DEPTH       = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic              XCLK,
  input  logic              XRES,
  input  logic              EN,
  input  logic              RE,
  input  logic              WE,
  input  logic [LANES-1:0]  BE,
  input  logic [31:0]       ADDR,
  input  logic [WORD_W-1:0] DATAI,
  output logic [WORD_W-1:0] DATAO,
  output logic              DACK,
  output logic              ERR,
  output logic              BUSY
`ifdef DARKRAM_PARITY_EN
  ,
  output logic              PERR
`endif
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam logic [32:0]           SPAN    = 33'(DEPTH) * 33'd4;
  localparam logic [WAIT_CNT_W-1:0] WS_LAST = WAIT_CNT_W'(WAIT_STATES - 1);

  state_e                   state_q, state_d;
  logic [WAIT_CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     oor_q, oor_d;
  logic                     rd_q, rd_d;
  logic [WORD_W-1:0]        dout_q, dout_d;
`ifdef DARKRAM_PARITY_EN
  logic                     perr_q, perr_d;
`endif

  logic [31:0]              offset;
  logic                     in_range;
  logic [IDX_W-1:0]         addr_idx;
  logic                     accept;
  logic [LANES-1:0]         wr_mask;
  logic [IDX_W-1:0]         arr_idx;
  logic [LANES-1:0][LANE_W-1:0] arr_wdata;
  logic [LANES-1:0][LANE_W-1:0] arr_rdata;
  logic [WORD_W-1:0]        rd_word;
  logic [WORD_W-1:0]        ack_data;
  logic                     par_bad;

  // Full 32-bit range check: an address below the base cannot wrap into the window.
  assign offset   = ADDR - BASE_ADDR;
  assign in_range = (ADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign addr_idx = offset[IDX_W+1:2];
  assign accept   = (state_q == IDLE) && EN && (RE || WE);

  // RE & WE together is a write. Out-of-range writes never touch the array.
  assign wr_mask  = (accept && WE && in_range) ? BE : '0;

  // While busy the array keeps re-reading the captured word; no write can
  // land in that window, so the data seen in ACK is the acceptance-edge sample.
  assign arr_idx  = (state_q == IDLE) ? addr_idx : idx_q;

  // Split the write word into lanes and attach parity where it is stored.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    arr_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      arr_wdata[i][BYTE_W-1:0] = DATAI[i*BYTE_W +: BYTE_W];
`ifdef DARKRAM_PARITY_EN
      arr_wdata[i][BYTE_W] = even_parity(DATAI[i*BYTE_W +: BYTE_W]);
`endif
    end
  end

  darkram_array #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (XCLK),
    .wr_mask (wr_mask),
    .idx     (arr_idx),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // Reassemble the raw data word and recompute lane parity on the read path.
  always_comb begin
    rd_word = '0;
    par_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rd_word[i*BYTE_W +: BYTE_W] = arr_rdata[i][BYTE_W-1:0];
`ifdef DARKRAM_PARITY_EN
      if (even_parity(arr_rdata[i][BYTE_W-1:0]) != arr_rdata[i][BYTE_W]) par_bad = 1'b1;
`endif
    end
  end

  assign ack_data = oor_q ? '0 : rd_word;

  // State register and captured request; async active-low reset.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
`ifdef DARKRAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
`ifdef DARKRAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) ACK -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (WAIT_STATES > 0) ? WAIT : ACK;
      WAIT:    if (cnt_q == WS_LAST) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counting, and the read-data hold register.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    oor_d  = oor_q;
    rd_d   = rd_q;
    dout_d = dout_q;
`ifdef DARKRAM_PARITY_EN
    perr_d = perr_q;
`endif
    if (accept) begin
      cnt_d = '0;
      idx_d = addr_idx;
      oor_d = !in_range;
      rd_d  = RE && !WE;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
    // Read data is presented straight from the array in ACK and kept afterwards.
    if ((state_q == ACK) && rd_q) dout_d = ack_data;
`ifdef DARKRAM_PARITY_EN
    if ((state_q == ACK) && rd_q && !oor_q && par_bad) perr_d = 1'b1;
`endif
  end

  // Moore outputs decoded from the state and captured request.
  always_comb begin
    DACK  = (state_q == ACK);
    BUSY  = (state_q != IDLE);
    ERR   = DACK && (oor_q || (rd_q && par_bad));
    DATAO = (DACK && rd_q) ? ack_data : dout_q;
  end

`ifdef DARKRAM_PARITY_EN
  assign PERR = perr_q;
`endif

endmodule

// File: tb/tb_darkram_ctrl.sv
// tb_darkram_ctrl: directed, table-driven bench for darkram_ctrl.
// Four instances share the bus (DEPTH=64, BASE=0x1000) with WAIT_STATES
// 1, 0, 5, 3; each has its own EN so requests target one instance.
module tb_darkram_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    int          inst;
    bit          re;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_do;
  } vec_t;

  logic        clk = 1'b0;
  logic        xres;
  logic [3:0]  en;
  logic        re, we;
  logic [3:0]  be;
  logic [31:0] addr, datai;
  logic [31:0] datao [4];
  logic [3:0]  dack, err, busy;
`ifdef DARKRAM_PARITY_EN
  logic [3:0]  perr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    darkram_ctrl #(
      .DEPTH       (64),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .XCLK  (clk),
      .XRES  (xres),
      .EN    (en[g]),
      .RE    (re),
      .WE    (we),
      .BE    (be),
      .ADDR  (addr),
      .DATAI (datai),
      .DATAO (datao[g]),
      .DACK  (dack[g]),
      .ERR   (err[g]),
      .BUSY  (busy[g])
`ifdef DARKRAM_PARITY_EN
      ,
      .PERR  (perr[g])
`endif
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    en    = '0;
    re    = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    addr  = 32'hFFFF_FFF0;  // junk, proves the request was captured
    datai = 32'h5A5A_5A5A;
  endtask

  task automatic drive(input int inst, input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    en       = '0;
    en[inst] = 1'b1;
    re       = r;
    we       = w;
    be       = b;
    addr     = a;
    datai    = d;
  endtask

  // Walks negedges until DACK of one instance; checks BUSY/ERR on the way.
  task automatic wait_ack(input int inst, input int lat0, input bit drop,
                          output int lat, output logic e, output logic [31:0] d);
    bit got = 0;
    lat = -1;
    e   = 1'b0;
    d   = '0;
    for (int c = lat0 + 1; c <= lat0 + 40 && !got; c++) begin
      @(negedge clk);
      if (drop && c == lat0 + 1) idle_bus();
      if (dack[inst]) begin
        got = 1;
        lat = c;
        e   = err[inst];
        d   = datao[inst];
      end else begin
        check($sformatf("u%0d busy_c%0d", inst, c), 32'(busy[inst]), 32'd1);
        check($sformatf("u%0d err_noack_c%0d", inst, c), 32'(err[inst]), 32'd0);
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL u%0d ack_timeout: got no DACK, want DACK within 40 cycles", inst);
    end
  endtask

  task automatic txn(input vec_t t, output int lat, output logic e, output logic [31:0] d);
    @(negedge clk);
    drive(t.inst, t.re, t.we, t.be, t.addr, t.data);
    wait_ack(t.inst, 0, 1'b1, lat, e, d);
  endtask

  // Run one vector and compare latency, ERR and DATAO.
  task automatic run(input string tag, input vec_t t);
    int          lat;
    logic        e;
    logic [31:0] d;
    txn(t, lat, e, d);
    check({tag, "_lat"}, 32'(lat), 32'(ws_of(t.inst) + 1));
    check({tag, "_err"}, 32'(e), 32'(t.exp_err));
    check({tag, "_do"},  d, t.exp_do);
  endtask

  function automatic vec_t v(input int inst, input bit r, input bit w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d,
                             input bit xe, input logic [31:0] xd);
    vec_t t;
    t.inst = inst; t.re = r; t.we = w; t.be = b;
    t.addr = a; t.data = d; t.exp_err = xe; t.exp_do = xd;
    return t;
  endfunction

  vec_t vecs [$];

  initial begin
    bit seen;

    // inst, re, we, be, addr, datai, exp_err, exp_datao
    vecs.push_back(v(0, 0, 1, 4'hF, 32'h0000_1010, 32'hDEAD_BEEF, 0, 32'h0000_0000));
    vecs.push_back(v(0, 0, 1, 4'h1, 32'h0000_1010, 32'h0000_00AA, 0, 32'h0000_0000));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_1010, 32'h0,         0, 32'hDEAD_BEAA));
    vecs.push_back(v(0, 0, 1, 4'hF, 32'h0000_10FC, 32'h0BAD_F00D, 0, 32'hDEAD_BEAA));
    vecs.push_back(v(0, 0, 1, 4'hF, 32'h0000_1100, 32'hFFFF_FFFF, 1, 32'hDEAD_BEAA));
    vecs.push_back(v(0, 0, 1, 4'hF, 32'h0000_0FFC, 32'hFFFF_FFFF, 1, 32'hDEAD_BEAA));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_1100, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_10FC, 32'h0,         0, 32'h0BAD_F00D));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_0FFC, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_10FF, 32'h0,         0, 32'h0BAD_F00D));
    vecs.push_back(v(0, 1, 1, 4'hF, 32'h0000_100C, 32'h1234_5678, 0, 32'h0BAD_F00D));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_100C, 32'h0,         0, 32'h1234_5678));
    vecs.push_back(v(0, 0, 1, 4'hF, 32'h0000_1020, 32'h1122_3344, 0, 32'h1234_5678));
    vecs.push_back(v(0, 0, 1, 4'h0, 32'h0000_1020, 32'hFFFF_FFFF, 0, 32'h1234_5678));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_1020, 32'h0,         0, 32'h1122_3344));
    vecs.push_back(v(0, 0, 1, 4'hA, 32'h0000_1020, 32'hAABB_CCDD, 0, 32'h1122_3344));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'h0000_1020, 32'h0,         0, 32'hAA22_CC44));
    vecs.push_back(v(0, 1, 0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(v(1, 0, 1, 4'hF, 32'h0000_1008, 32'hCAFE_0001, 0, 32'h0000_0000));
    vecs.push_back(v(1, 1, 0, 4'h0, 32'h0000_1008, 32'h0,         0, 32'hCAFE_0001));
    vecs.push_back(v(1, 1, 0, 4'h0, 32'h0000_1100, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(v(2, 0, 1, 4'hF, 32'h0000_1040, 32'h1357_9BDF, 0, 32'h0000_0000));
    vecs.push_back(v(2, 1, 0, 4'h0, 32'h0000_1040, 32'h0,         0, 32'h1357_9BDF));
    vecs.push_back(v(2, 1, 0, 4'h0, 32'h0000_0000, 32'h0,         1, 32'h0000_0000));

    // Reset state
    idle_bus();
    xres = 1'b0;
    repeat (3) @(negedge clk);
    xres = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_u%0d_dack", k), 32'(dack[k]), 32'd0);
      check($sformatf("rst_u%0d_busy", k), 32'(busy[k]), 32'd0);
      check($sformatf("rst_u%0d_do", k), datao[k], 32'h0);
    end
    check("rst_u0_err", 32'(err[0]), 32'd0);

    // Table-driven vectors
    foreach (vecs[i]) run($sformatf("v%0d", i), vecs[i]);

    // Request during BUSY is ignored (u2, WAIT_STATES=5)
    begin
      int          lat;
      logic        e;
      logic [31:0] d;
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 4'h0, 32'h0000_1040, 32'h0);
      @(negedge clk);
      check("busy_c1", 32'(busy[2]), 32'd1);
      drive(2, 1'b0, 1'b1, 4'hF, 32'h0000_1040, 32'hFFFF_FFFF);
      @(negedge clk);
      check("busy_c2", 32'(busy[2]), 32'd1);
      @(negedge clk);
      check("busy_c3", 32'(busy[2]), 32'd1);
      idle_bus();
      wait_ack(2, 3, 1'b0, lat, e, d);
      check("busy_lat", 32'(lat), 32'd6);
      check("busy_do", d, 32'h1357_9BDF);
      @(negedge clk);
      check("busy_pulse_dack", 32'(dack[2]), 32'd0);
      check("busy_pulse_busy", 32'(busy[2]), 32'd0);
      check("busy_hold_do", datao[2], 32'h1357_9BDF);
    end
    run("busy_after", v(2, 1, 0, 4'h0, 32'h0000_1040, 32'h0, 0, 32'h1357_9BDF));

    // Reset in the middle of a read (u3, WAIT_STATES=3)
    run("r3_wr", v(3, 0, 1, 4'hF, 32'h0000_1080, 32'h0F0F_0F0F, 0, 32'h0));
    run("r3_rd", v(3, 1, 0, 4'h0, 32'h0000_1080, 32'h0, 0, 32'h0F0F_0F0F));
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 4'h0, 32'h0000_1080, 32'h0);
    @(negedge clk);
    idle_bus();
    check("rmid_busy_pre", 32'(busy[3]), 32'd1);
    @(negedge clk);
    xres = 1'b0;
    #1;
    check("rmid_busy_rst", 32'(busy[3]), 32'd0);
    check("rmid_do_rst", datao[3], 32'h0);
    @(negedge clk);
    xres = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dack[3]) seen = 1;
    end
    check("rmid_no_dack", 32'(seen), 32'd0);
    check("rmid_busy_post", 32'(busy[3]), 32'd0);
    check("rmid_do_post", datao[3], 32'h0);

    // Reset right after a write is accepted: the write still lands
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 4'hF, 32'h0000_1084, 32'hA5A5_A5A5);
    @(negedge clk);
    idle_bus();
    xres = 1'b0;
    @(negedge clk);
    xres = 1'b1;
    run("wmid_rd", v(3, 1, 0, 4'h0, 32'h0000_1084, 32'h0, 0, 32'hA5A5_A5A5));
    // Memory survives reset
    run("keep_rd", v(0, 1, 0, 4'h0, 32'h0000_1010, 32'h0, 0, 32'hDEAD_BEAA));

`ifdef DARKRAM_PARITY_EN
    check("perr_init", 32'(perr[0]), 32'd0);
    run("par_wr", v(0, 0, 1, 4'hF, 32'h0000_1030, 32'h0102_0304, 0, 32'hDEAD_BEAA));
    run("par_rd_ok", v(0, 1, 0, 4'h0, 32'h0000_1030, 32'h0, 0, 32'h0102_0304));
    check("perr_clean", 32'(perr[0]), 32'd0);
    @(negedge clk);
    g_dut[0].u_dut.u_array.mem[12][2][0] = ~g_dut[0].u_dut.u_array.mem[12][2][0];
    run("par_rd_bad", v(0, 1, 0, 4'h0, 32'h0000_1030, 32'h0, 1, 32'h0103_0304));
    @(negedge clk);
    check("perr_set", 32'(perr[0]), 32'd1);
    run("par_rd_clean", v(0, 1, 0, 4'h0, 32'h0000_1010, 32'h0, 0, 32'hDEAD_BEAA));
    check("perr_sticky", 32'(perr[0]), 32'd1);
    xres = 1'b0;
    @(negedge clk);
    xres = 1'b1;
    @(negedge clk);
    check("perr_rst", 32'(perr[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
